// File: rtl/otbn_keccak_theta_unit.sv
// Keccak theta column unit: absorbs 25 lanes into column parities C[0..4],
// then derives D[x] = C[x-1] ^ rotl(C[x+1], 1) one column per cycle.
module otbn_keccak_theta_unit #(
    parameter int DataW = 256,
    parameter int LaneW = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             lane_valid_i,
    output logic             lane_ready_o,
    input  logic [DataW-1:0] lane_i,
    input  logic [1:0]       lane_w_sel_i,
    input  logic [2:0]       lane_x_i,
    input  logic [2:0]       d_x_i,
    input  logic [1:0]       d_w_sel_i,
    output logic [DataW-1:0] d_o,
    output logic             d_valid_o,
    output logic             busy_o,
    output logic             err_o
);

    typedef enum logic [1:0] {IDLE, ABSORB, COMPUTE, READY} state_e;

    state_e             state_q, state_d;
    logic [LaneW-1:0]   c_p0 [0:4];
    logic [LaneW-1:0]   d_p1 [0:4];
    logic [4:0]         lane_cnt_q;
    logic [2:0]         comp_cnt_q;
    logic               err_q;
    logic               vld_p2;
    logic               hs;
    logic               lane_ok;
    logic [LaneW-1:0]   lane_word;

    function automatic logic [LaneW-1:0] rotl1(input logic [LaneW-1:0] v);
        return {v[LaneW-2:0], v[LaneW-1]};
    endfunction

    function automatic logic [2:0] col_prev(input logic [2:0] x);
        return (x == 3'd0) ? 3'd4 : x - 3'd1;
    endfunction

    function automatic logic [2:0] col_next(input logic [2:0] x);
        return (x == 3'd4) ? 3'd0 : x + 3'd1;
    endfunction

    assign lane_ready_o = (state_q == ABSORB) & ~start_i;
    assign hs           = lane_valid_i & lane_ready_o;
    assign lane_ok      = (lane_x_i <= 3'd4);
    assign lane_word    = lane_i[LaneW*lane_w_sel_i +: LaneW];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (start_i) begin
            state_d = ABSORB;
        end else begin
            unique case (state_q)
                ABSORB:  if (hs && lane_ok && lane_cnt_q == 5'd24) state_d = COMPUTE;
                COMPUTE: if (comp_cnt_q == 3'd4) state_d = READY;
                default: state_d = state_q;
            endcase
        end
    end

    // absorb stage (C, p0) -> compute stage (D, p1) -> readable flag (p2)
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < 5; i++) begin
                c_p0[i] <= '0;
                d_p1[i] <= '0;
            end
            lane_cnt_q <= '0;
            comp_cnt_q <= '0;
            err_q      <= 1'b0;
            vld_p2     <= 1'b0;
        end else if (start_i) begin
            for (int i = 0; i < 5; i++) begin
                c_p0[i] <= '0;
                d_p1[i] <= '0;
            end
            lane_cnt_q <= '0;
            comp_cnt_q <= '0;
            err_q      <= 1'b0;
            vld_p2     <= 1'b0;
        end else begin
            if (hs && lane_ok) begin
                c_p0[lane_x_i] <= c_p0[lane_x_i] ^ lane_word;
                lane_cnt_q     <= lane_cnt_q + 5'd1;
            end
            if (hs && !lane_ok) begin
                err_q <= 1'b1;
            end
            if (state_q == COMPUTE) begin
                d_p1[comp_cnt_q] <= c_p0[col_prev(comp_cnt_q)] ^ rotl1(c_p0[col_next(comp_cnt_q)]);
                comp_cnt_q       <= comp_cnt_q + 3'd1;
            end
            if (state_q == READY && d_x_i > 3'd4) begin
                err_q <= 1'b1;
            end
            vld_p2 <= (state_q == READY);
        end
    end

    always_comb begin
        d_o    = '0;
        busy_o = (state_q == ABSORB) || (state_q == COMPUTE);
        if (state_q == READY && d_x_i <= 3'd4) begin
            d_o[LaneW*d_w_sel_i +: LaneW] = d_p1[d_x_i];
        end
    end

    assign d_valid_o = vld_p2;
    assign err_o     = err_q;

endmodule

// File: tb/tb_otbn_keccak_theta_unit.sv
// Directed bench for otbn_keccak_theta_unit: hand-computed theta vectors plus
// a column-parity reference for the randomised lane sequences.
module tb_otbn_keccak_theta_unit;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         start_i;
    logic         lane_valid_i;
    logic         lane_ready_o;
    logic [255:0] lane_i;
    logic [1:0]   lane_w_sel_i;
    logic [2:0]   lane_x_i;
    logic [2:0]   d_x_i;
    logic [1:0]   d_w_sel_i;
    logic [255:0] d_o;
    logic         d_valid_o;
    logic         busy_o;
    logic         err_o;

    int vecs = 0;
    int miscompares = 0;
    int cyc = 0;
    int acc_cyc = 0;
    logic [63:0] c_ref [0:4];

    otbn_keccak_theta_unit #(.DataW(256), .LaneW(64)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
        .lane_valid_i(lane_valid_i), .lane_ready_o(lane_ready_o),
        .lane_i(lane_i), .lane_w_sel_i(lane_w_sel_i), .lane_x_i(lane_x_i),
        .d_x_i(d_x_i), .d_w_sel_i(d_w_sel_i), .d_o(d_o),
        .d_valid_o(d_valid_o), .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
        vecs++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] rand256();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [63:0] theta_ref(input int x);
        logic [63:0] n;
        n = c_ref[(x + 1) % 5];
        return c_ref[(x + 4) % 5] ^ {n[62:0], n[63]};
    endfunction

    task automatic do_start(input logic with_lane);
        @(negedge clk_i);
        start_i      = 1'b1;
        lane_valid_i = with_lane;
        lane_x_i     = 3'd0;
        lane_w_sel_i = 2'd0;
        lane_i       = rand256() | 256'h1;
        #1;
        check_val("ready_with_start", 256'(lane_ready_o), 256'd0);
        @(negedge clk_i);
        start_i      = 1'b0;
        lane_valid_i = 1'b0;
        for (int i = 0; i < 5; i++) c_ref[i] = '0;
        check_val("start_busy", 256'(busy_o), 256'd1);
        check_val("start_err_clear", 256'(err_o), 256'd0);
        check_val("start_dvalid", 256'(d_valid_o), 256'd0);
    endtask

    task automatic send_lane(input logic [2:0] x, input logic [63:0] val,
                             input logic [1:0] wsel, input int gap);
        logic ok;
        repeat (gap) @(negedge clk_i);
        @(negedge clk_i);
        lane_valid_i = 1'b1;
        lane_x_i     = x;
        lane_w_sel_i = wsel;
        lane_i       = rand256();
        lane_i[64*wsel +: 64] = val;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (lane_ready_o) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk_i);
        end
        if (!ok) check_val("lane_accept_timeout", 256'd0, 256'd1);
        @(posedge clk_i);
        #1;
        lane_valid_i = 1'b0;
        acc_cyc = cyc;
        if (ok && x <= 3'd4) c_ref[x] = c_ref[x] ^ val;
    endtask

    task automatic feed(input int n, input logic rnd, input int max_gap);
        for (int i = 0; i < n; i++) begin
            send_lane(3'(i % 5), rnd ? {$urandom, $urandom} : 64'd0, 2'($urandom_range(0, 3)),
                      (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
        end
    endtask

    task automatic wait_dvalid(input string tag);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk_i);
            if (d_valid_o) begin
                ok = 1'b1;
                break;
            end
        end
        check_val({tag, "_dvalid"}, 256'(ok), 256'd1);
        if (ok) check_val({tag, "_latency"}, 256'(cyc - acc_cyc), 256'd6);
    endtask

    task automatic read_d(input string tag, input logic [2:0] x, input logic [1:0] wsel,
                          input logic [63:0] exp);
        logic [255:0] e;
        @(negedge clk_i);
        d_x_i     = x;
        d_w_sel_i = wsel;
        #1;
        e = '0;
        e[64*wsel +: 64] = exp;
        check_val(tag, d_o, e);
    endtask

    task automatic check_model(input string tag);
        for (int x = 0; x < 5; x++) begin
            read_d(tag, 3'(x), 2'((x + 1) % 4), theta_ref(x));
        end
    endtask

    initial begin
        rst_i = 1'b1; start_i = 1'b0; lane_valid_i = 1'b0; lane_i = '0;
        lane_w_sel_i = '0; lane_x_i = '0; d_x_i = '0; d_w_sel_i = '0;
        for (int i = 0; i < 5; i++) c_ref[i] = '0;

        repeat (2) @(negedge clk_i);
        check_val("rst_ready", 256'(lane_ready_o), 256'd0);
        check_val("rst_dvalid", 256'(d_valid_o), 256'd0);
        check_val("rst_busy", 256'(busy_o), 256'd0);
        check_val("rst_err", 256'(err_o), 256'd0);
        check_val("rst_d_o", d_o, 256'd0);
        @(negedge clk_i) rst_i = 1'b0;
        @(negedge clk_i);
        check_val("idle_ready", 256'(lane_ready_o), 256'd0);

        // all-zero state
        do_start(1'b0);
        feed(25, 1'b0, 0);
        wait_dvalid("zero");
        check_val("ready_not_busy", 256'(busy_o), 256'd0);
        for (int x = 0; x < 5; x++) read_d("zero_d", 3'(x), 2'(x % 4), 64'd0);

        // single bit in column 1
        do_start(1'b0);
        send_lane(3'd1, 64'h1, 2'd0, 0);
        feed(24, 1'b0, 0);
        wait_dvalid("bit1");
        read_d("bit1_d0_w3", 3'd0, 2'd3, 64'h2);
        read_d("bit1_d1", 3'd1, 2'd0, 64'h0);
        read_d("bit1_d2", 3'd2, 2'd1, 64'h1);
        read_d("bit1_d3", 3'd3, 2'd2, 64'h0);
        read_d("bit1_d4", 3'd4, 2'd0, 64'h0);
        repeat (10) @(negedge clk_i);
        read_d("bit1_persist", 3'd2, 2'd0, 64'h1);
        check_val("bit1_err", 256'(err_o), 256'd0);
        @(negedge clk_i);
        d_x_i = 3'd5;
        d_w_sel_i = 2'd0;
        #1;
        check_val("badx_d_o", d_o, 256'd0);
        @(negedge clk_i);
        check_val("badx_err", 256'(err_o), 256'd1);
        d_x_i = 3'd0;

        // rotation wrap from bit 63
        do_start(1'b0);
        send_lane(3'd3, 64'h8000_0000_0000_0000, 2'd2, 0);
        feed(24, 1'b0, 0);
        wait_dvalid("wrap");
        read_d("wrap_d0", 3'd0, 2'd1, 64'h0);
        read_d("wrap_d1", 3'd1, 2'd2, 64'h0);
        read_d("wrap_d2", 3'd2, 2'd0, 64'h1);
        read_d("wrap_d3", 3'd3, 2'd1, 64'h0);
        read_d("wrap_d4", 3'd4, 2'd3, 64'h8000_0000_0000_0000);

        // out-of-range column consumed without counting
        do_start(1'b0);
        feed(10, 1'b1, 0);
        send_lane(3'd5, 64'hdead_beef_0000_0001, 2'd1, 0);
        @(negedge clk_i);
        check_val("badlane_err", 256'(err_o), 256'd1);
        feed(14, 1'b1, 0);
        @(negedge clk_i);
        check_val("badlane_still_absorb", 256'(lane_ready_o), 256'd1);
        feed(1, 1'b1, 0);
        wait_dvalid("badlane");
        check_model("badlane_d");
        check_val("badlane_err_sticky", 256'(err_o), 256'd1);

        // restart after 12 lanes
        do_start(1'b0);
        feed(12, 1'b1, 0);
        do_start(1'b0);
        feed(25, 1'b1, 0);
        wait_dvalid("restart");
        check_model("restart_d");

        // reset during COMPUTE
        do_start(1'b0);
        feed(25, 1'b1, 0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        check_val("midrst_busy", 256'(busy_o), 256'd0);
        check_val("midrst_dvalid", 256'(d_valid_o), 256'd0);
        check_val("midrst_d_o", d_o, 256'd0);
        @(negedge clk_i) rst_i = 1'b0;
        repeat (8) @(negedge clk_i);
        check_val("postrst_dvalid", 256'(d_valid_o), 256'd0);
        check_val("postrst_busy", 256'(busy_o), 256'd0);
        do_start(1'b0);
        feed(25, 1'b1, 0);
        wait_dvalid("postrst");
        check_model("postrst_d");

        // lane offered with start, then gapped traffic
        do_start(1'b1);
        feed(25, 1'b1, 3);
        wait_dvalid("gaps");
        check_model("gaps_d");

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

endmodule

// File: doc/otbn_keccak_theta_unit.md
OTBN_KECCAK_THETA_UNIT -- requirements
Module: otbn_keccak_theta_unit

Interface
REQ-001 Parameter: DataW, default 256, WDR width; fixed at 256, other values unsupported.
REQ-002 Parameter: LaneW, default 64, Keccak lane width; fixed at 64.
REQ-003 clk_i  in  1  single clock; all state updates on rising edge.
REQ-004 rst_i  in  1  asynchronous, active-high reset.
REQ-005 start_i  in  1  one-cycle pulse: clear accumulators, begin absorbing a new 25-lane state.
REQ-006 lane_valid_i  in  1  lane offered this cycle.
REQ-007 lane_ready_o  out  1  block accepts lane; handshake = lane_valid_i & lane_ready_o.
REQ-008 lane_i  in  256  WDR holding the lane.
REQ-009 lane_w_sel_i  in  2  selects 64-bit word k of lane_i, i.e. lane_i[64k+:64].
REQ-010 lane_x_i  in  3  column index x of the offered lane, valid range 0..4.
REQ-011 d_x_i  in  3  column index of the theta word D[x] to read.
REQ-012 d_w_sel_i  in  2  output word slot for D[x] in d_o.
REQ-013 d_o  out  256  D[d_x_i] placed at d_o[64*d_w_sel_i+:64]; all other bits zero.
REQ-014 d_valid_o  out  1  D register file complete and readable.
REQ-015 busy_o  out  1  high in ABSORB or COMPUTE.
REQ-016 err_o  out  1  sticky: out-of-range lane_x_i or d_x_i seen since last start_i.

Function
REQ-017 The FSM SHALL have states IDLE, ABSORB, COMPUTE, READY.
REQ-018 start_i SHALL, in any state, clear C[0..4], D[0..4], lane counter, compute counter and err_o, and enter ABSORB on the next edge.
REQ-019 lane_ready_o SHALL equal (state==ABSORB) & ~start_i; a lane offered alongside start_i SHALL NOT be accepted.
REQ-020 On each handshake with lane_x_i<=4, C[lane_x_i] SHALL be XORed with the selected 64-bit word and the 5-bit lane counter incremented.
REQ-021 On a handshake with lane_x_i>4, the lane SHALL be consumed without updating C or the counter, and err_o set.
REQ-022 A handshake that brings the counter to 25 SHALL move the FSM to COMPUTE on that edge; per-column lane counts are not checked.
REQ-023 COMPUTE SHALL last exactly 5 cycles, computing one column per cycle in order x=0..4: D[x] = C[(x+4) mod 5] XOR rotl(C[(x+1) mod 5], 1).
REQ-024 After the 5th COMPUTE cycle the FSM SHALL enter READY; d_valid_o SHALL rise 6 cycles after the edge accepting the 25th lane.
REQ-025 In READY, d_o SHALL be combinational from D[d_x_i], d_x_i and d_w_sel_i; outside READY, d_o SHALL be zero.
REQ-026 In READY, d_x_i>4 SHALL drive d_o to zero and set err_o.
REQ-027 READY SHALL persist until start_i or reset; reads are non-destructive and unlimited.
REQ-028 lane_valid_i gaps SHALL stall ABSORB without state loss; lane inputs are ignored outside ABSORB.
REQ-029 All XOR and rotation operations SHALL be on 64-bit quantities; rotl is modulo 64, with bit 63 wrapping to bit 0.

Reset
REQ-030 While rst_i is high: state=IDLE, C, D and all counters zero, and lane_ready_o=0, d_valid_o=0, busy_o=0, err_o=0, d_o=0.
REQ-031 rst_i asserted mid-ABSORB or mid-COMPUTE SHALL discard all partial results; a fresh start_i is required afterwards.

Verification
REQ-032 start_i, 25 all-zero lanes with x cycling 0..4 -> d_valid_o high 6 cycles after the last accept; D[0..4]=0.
REQ-033 start_i, one lane x=1 value 64'h1, 24 zero lanes -> D[0]=64'h2, D[2]=64'h1, D[1]=D[3]=D[4]=0; d_x_i=0, d_w_sel_i=3 -> d_o[255:192]=64'h2, rest zero.
REQ-034 Lane x=3 value 64'h8000_0000_0000_0000 plus zero lanes -> D[2]=64'h1 (wrap), D[4]=64'h8000_0000_0000_0000.
REQ-035 Lane with lane_x_i=5 mid-ABSORB -> err_o=1, counter unchanged, 26 handshakes needed to reach COMPUTE; next start_i clears err_o.
REQ-036 start_i after 12 lanes, and separately rst_i during COMPUTE -> accumulators zeroed, d_valid_o low; full 25-lane sequence then gives correct D.
REQ-037 Random lane_valid_i gaps and a lane_valid_i asserted alongside start_i -> the lane offered with start_i is not accepted; D matches a reference theta model.
